phys_free_list: RTL and testbench

PHYS_FREE_LIST -- requirements
Module: phys_free_list

---
 rtl/phys_free_list.sv | 102 ++++++++++
 tb/tb_phys_free_list.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/phys_free_list.sv
// Physical register free list: circular FIFO of free tags with an in-list bitmap
// that screens double frees; one allocation and up to two frees per cycle.
module phys_free_list #(
    parameter int unsigned NUM_PREG = 64,
    parameter int unsigned NUM_AREG = 32,
    parameter int unsigned TAG_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    output logic             alloc_valid,
    output logic [TAG_W-1:0] alloc_preg,
    input  logic             free0_valid,
    input  logic [TAG_W-1:0] free0_preg,
    input  logic             free1_valid,
    input  logic [TAG_W-1:0] free1_preg,
    output logic [TAG_W:0]   free_count,
    output logic             empty,
    output logic             err
);
    localparam int unsigned NUM_FREE = NUM_PREG - NUM_AREG;

    logic [TAG_W-1:0]    fifo_q [NUM_PREG];
    logic [TAG_W-1:0]    fifo_d [NUM_PREG];
    logic [TAG_W-1:0]    head_q, head_d;
    logic [TAG_W-1:0]    tail_q, tail_d;
    logic [TAG_W:0]      count_q, count_d;
    logic [NUM_PREG-1:0] in_list_q, in_list_d;
    logic                err_q, err_d;

    logic             alloc_fire;
    logic             f0_acc, f0_bad;
    logic             f1_acc, f1_bad;
    logic             f_dup;
    logic [TAG_W-1:0] tail_p1;

    // Pointer add with explicit modulo so non-power-of-two depths also wrap correctly.
    function automatic logic [TAG_W-1:0] ptr_add(input logic [TAG_W-1:0] p, input logic [1:0] n);
        logic [TAG_W+1:0] s;
        s = {2'b00, p} + {{TAG_W{1'b0}}, n};
        if (s >= (TAG_W+2)'(NUM_PREG)) begin
            s = s - (TAG_W+2)'(NUM_PREG);
        end
        return s[TAG_W-1:0];
    endfunction

    assign empty       = (count_q == '0);
    assign alloc_valid = !empty;
    assign alloc_preg  = fifo_q[head_q];
    assign free_count  = count_q;
    assign err         = err_q;

    always_comb begin
        alloc_fire = alloc_req && !empty;
        // Acceptance uses the pre-edge bitmap, so a tag freed this cycle cannot be granted until next cycle.
        f_dup  = free0_valid && free1_valid && (free0_preg == free1_preg);
        f0_acc = free0_valid && (free0_preg != '0) && !in_list_q[free0_preg];
        f0_bad = free0_valid && (free0_preg != '0) && in_list_q[free0_preg];
        f1_acc = free1_valid && (free1_preg != '0) && !in_list_q[free1_preg] && !f_dup;
        f1_bad = free1_valid && (free1_preg != '0) && (in_list_q[free1_preg] || f_dup);
        tail_p1 = ptr_add(tail_q, 2'd1);

        fifo_d    = fifo_q;
        in_list_d = in_list_q;
        if (alloc_fire) begin
            in_list_d[fifo_q[head_q]] = 1'b0;
        end
        if (f0_acc) begin
            fifo_d[tail_q]        = free0_preg;
            in_list_d[free0_preg] = 1'b1;
        end
        if (f1_acc) begin
            fifo_d[f0_acc ? tail_p1 : tail_q] = free1_preg;
            in_list_d[free1_preg]             = 1'b1;
        end

        head_d  = alloc_fire ? ptr_add(head_q, 2'd1) : head_q;
        tail_d  = ptr_add(tail_q, {f0_acc & f1_acc, f0_acc ^ f1_acc});
        count_d = count_q - (TAG_W+1)'(alloc_fire) + (TAG_W+1)'(f0_acc) + (TAG_W+1)'(f1_acc);
        err_d   = err_q | f0_bad | f1_bad;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_PREG; i++) begin
                fifo_q[i]    <= (i < NUM_FREE) ? TAG_W'(i + NUM_AREG) : '0;
                in_list_q[i] <= (i >= NUM_AREG);
            end
            head_q  <= '0;
            tail_q  <= TAG_W'(NUM_FREE);
            count_q <= (TAG_W+1)'(NUM_FREE);
            err_q   <= 1'b0;
        end else begin
            fifo_q    <= fifo_d;
            in_list_q <= in_list_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_phys_free_list.sv
// Bench for phys_free_list: directed vector table for the corner cases, then
// randomized traffic against a queue-based model of the free list.
module tb_phys_free_list;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       alloc_req = 1'b0;
    logic       alloc_valid;
    logic [5:0] alloc_preg;
    logic       free0_valid = 1'b0;
    logic [5:0] free0_preg = '0;
    logic       free1_valid = 1'b0;
    logic [5:0] free1_preg = '0;
    logic [6:0] free_count;
    logic       empty;
    logic       err;

    int n_cmp = 0;
    int n_mis = 0;

    phys_free_list #(.NUM_PREG(64), .NUM_AREG(32), .TAG_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_req   (alloc_req),
        .alloc_valid (alloc_valid),
        .alloc_preg  (alloc_preg),
        .free0_valid (free0_valid),
        .free0_preg  (free0_preg),
        .free1_valid (free1_valid),
        .free1_preg  (free1_preg),
        .free_count  (free_count),
        .empty       (empty),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        bit alloc;
        bit f0v;
        int f0p;
        bit f1v;
        int f1p;
        bit e_valid;
        int e_preg;
        int e_count;
        bit e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit a, bit f0v, int f0p, bit f1v, int f1p,
                                bit ev, int ep, int ec, bit ee);
        vec_t v;
        v.rst = r; v.alloc = a; v.f0v = f0v; v.f0p = f0p; v.f1v = f1v; v.f1p = f1p;
        v.e_valid = ev; v.e_preg = ep; v.e_count = ec; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input bit ev, input int ep, input int ec, input bit ee);
        chk({tag, ".alloc_valid"}, int'(alloc_valid), int'(ev));
        chk({tag, ".empty"}, int'(empty), int'(ec == 0));
        chk({tag, ".free_count"}, int'(free_count), ec);
        chk({tag, ".err"}, int'(err), int'(ee));
        if (ev) chk({tag, ".alloc_preg"}, int'(alloc_preg), ep);
    endtask

    // Reference model: free tags as a plain queue in grant order plus a membership array.
    int q[$];
    bit m_in[64];
    bit m_err;

    function automatic void model_reset();
        q.delete();
        for (int i = 0; i < 64; i++) m_in[i] = 1'b0;
        for (int i = 32; i < 64; i++) begin
            q.push_back(i);
            m_in[i] = 1'b1;
        end
        m_err = 1'b0;
    endfunction

    function automatic void model_step(bit a, bit f0v, int f0p, bit f1v, int f1p);
        bit acc0, acc1, same;
        int t;
        same = f0v && f1v && (f0p == f1p) && (f0p != 0);
        acc0 = f0v && (f0p != 0) && !m_in[f0p];
        acc1 = f1v && (f1p != 0) && !m_in[f1p] && !same;
        if (f0v && (f0p != 0) && m_in[f0p]) m_err = 1'b1;
        if (f1v && (f1p != 0) && (m_in[f1p] || same)) m_err = 1'b1;
        if (a && q.size() > 0) begin
            t = q.pop_front();
            m_in[t] = 1'b0;
        end
        if (acc0) begin q.push_back(f0p); m_in[f0p] = 1'b1; end
        if (acc1) begin q.push_back(f1p); m_in[f1p] = 1'b1; end
    endfunction

    initial begin
        // Directed table: expectations are the outputs seen while that vector is applied.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32, 32, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 32, 32, 0));
        vecs.push_back(mk(0, 0, 1, 40, 0, 0, 1, 32, 32, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32, 32, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32, 32, 0));
        for (int i = 0; i < 32; i++)
            vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 32 + i, 32 - i, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 5, 1, 7, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 2, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 5, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7, 1, 0));
        vecs.push_back(mk(0, 0, 1, 9, 1, 9, 1, 7, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7, 2, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 7, 2, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 9, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 9, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst         = vecs[i].rst;
            alloc_req   = vecs[i].alloc;
            free0_valid = vecs[i].f0v;
            free0_preg  = 6'(vecs[i].f0p);
            free1_valid = vecs[i].f1v;
            free1_preg  = 6'(vecs[i].f1p);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_preg,
                       vecs[i].e_count, vecs[i].e_err);
        end

        // Randomized recycling traffic with a mid-run asynchronous reset.
        @(negedge clk);
        rst = 1'b1; alloc_req = 1'b0; free0_valid = 1'b0; free1_valid = 1'b0;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rst         = (c == 250);
            alloc_req   = ($urandom_range(99) < 55);
            free0_valid = ($urandom_range(99) < 50);
            free0_preg  = 6'($urandom_range(63));
            free1_valid = ($urandom_range(99) < 35);
            free1_preg  = ($urandom_range(9) == 0) ? free0_preg : 6'($urandom_range(63));
            if (rst) model_reset();
            #1;
            check_outs($sformatf("rnd%0d", c), q.size() > 0, (q.size() > 0) ? q[0] : 0,
                       q.size(), m_err);
            if (!rst) model_step(alloc_req, free0_valid, int'(free0_preg),
                                 free1_valid, int'(free1_preg));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_mis);
        $finish;
    end
endmodule
